// File: rtl/mult8x8_seq_ctrl.sv
// Unsigned 8x8 multiplier sequencer: time-shares an external 4x4 core over four
// steps and shift-accumulates the nibble partial products into a 16-bit result.
module mult8x8_seq_ctrl #(
   parameter bit ZERO_SKIP = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  step;
   logic [15:0] acc;
   logic [15:0] acc_sum;
   logic [7:0]  a_r, b_r;
   logic [15:0] product_r;
   logic        accept;
   logic        zero_op;

   // Place a nibble partial product at its weight: lo*lo, cross terms, hi*hi.
   function automatic logic [15:0] align_pp(input logic [7:0] pp, input logic [1:0] stp);
      logic [15:0] r;
      case (stp)
         2'd0:    r = {8'h00, pp};
         2'd1,
         2'd2:    r = {4'h0, pp, 4'h0};
         default: r = {pp, 8'h00};
      endcase
      return r;
   endfunction

   // in_ready is held low during reset so no transfer can be seen by upstream.
   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign zero_op  = ZERO_SKIP && ((a == 8'h00) || (b == 8'h00));
   assign acc_sum  = acc + align_pp(mul_p, step);
   assign product  = product_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      mul_a     = 4'h0;
      mul_b     = 4'h0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = zero_op ? DONE : MUL;
         end
         MUL: begin
            busy  = 1'b1;
            // step[1] selects the high nibble of a, step[0] the high nibble of b
            mul_a = step[1] ? a_r[7:4] : a_r[3:0];
            mul_b = step[0] ? b_r[7:4] : b_r[3:0];
            if (step == 2'd3) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (accept) state_nxt = zero_op ? DONE : MUL;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step      <= 2'd0;
         acc       <= 16'h0000;
         a_r       <= 8'h00;
         b_r       <= 8'h00;
         product_r <= 16'h0000;
      end else if (accept) begin
         a_r  <= a;
         b_r  <= b;
         acc  <= 16'h0000;
         step <= 2'd0;
         if (zero_op) product_r <= 16'h0000;
      end else if (state == MUL) begin
         acc  <= acc_sum;
         step <= step + 2'd1;
         if (step == 2'd3) product_r <= acc_sum;
      end
   end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Scoreboard bench for mult8x8_seq_ctrl: stimulus pushes expected products,
// monitors pop and compare on every output handshake.
module tb_mult8x8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  a, b, mul_p;
   logic [15:0] product;
   logic [3:0]  mul_a, mul_b;

   logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
   logic [7:0]  z_a, z_b, z_mul_p;
   logic [15:0] z_product;
   logic [3:0]  z_mul_a, z_mul_b;

   assign mul_p   = {4'h0, mul_a} * {4'h0, mul_b};
   assign z_mul_p = {4'h0, z_mul_a} * {4'h0, z_mul_b};

   mult8x8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy));

   mult8x8_seq_ctrl #(.ZERO_SKIP(1'b1)) dutz (
      .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .a(z_a), .b(z_b),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .product(z_product),
      .mul_a(z_mul_a), .mul_b(z_mul_b), .mul_p(z_mul_p), .busy(z_busy));

   int          nchk = 0;
   int          nerr = 0;
   logic [15:0] exp_q[$];
   logic [15:0] zexp_q[$];
   bit          zbusy_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, presents a/b for one accept edge, returns #1 after it.
   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      exp_q.push_back(ev);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'hEE;
      b = 8'hDD;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk("valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic step_chk(input logic [3:0] ea, input logic [3:0] eb);
      chk("mul_a", {28'd0, mul_a}, {28'd0, ea});
      chk("mul_b", {28'd0, mul_b}, {28'd0, eb});
      chk("busy_mul", {31'd0, busy}, 32'd1);
      chk("no_early_valid", {31'd0, out_valid}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL sb_unexpected: got product %0h with no expected entry", product);
         end else begin
            chk("sb_product", {16'd0, product}, {16'd0, exp_q.pop_front()});
         end
      end
      if (!rst && z_out_valid && z_out_ready) begin
         if (zexp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL zsb_unexpected: got product %0h with no expected entry", z_product);
         end else begin
            chk("zsb_product", {16'd0, z_product}, {16'd0, zexp_q.pop_front()});
         end
      end
      if (z_busy) zbusy_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
      z_in_valid = 1'b0; z_a = 8'h00; z_b = 8'h00; z_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_product", {16'd0, product}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mul", {24'd0, mul_a, mul_b}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // nibble schedule and 4-cycle latency
      send(8'h12, 8'h34, 16'h03A8);
      step_chk(4'h2, 4'h4); tick();
      step_chk(4'h2, 4'h3); tick();
      step_chk(4'h1, 4'h4); tick();
      step_chk(4'h1, 4'h3); tick();
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_product", {16'd0, product}, 32'h03A8);
      chk("done_mul_zero", {24'd0, mul_a, mul_b}, 32'd0);
      tick();
      chk("handoff_drop", {31'd0, out_valid}, 32'd0);

      // extremes
      send(8'hFF, 8'hFF, 16'hFE01);
      wait_valid();
      chk("max_product", {16'd0, product}, 32'hFE01);
      tick();
      send(8'h01, 8'h80, 16'h0080);
      wait_valid();
      chk("one_product", {16'd0, product}, 32'h0080);
      tick();

      // backpressure: hold result, ignore new operands
      out_ready = 1'b0;
      send(8'hA5, 8'h3C, 16'h26AC);
      wait_valid();
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         chk("hold_product", {16'd0, product}, 32'h26AC);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("release_drop", {31'd0, out_valid}, 32'd0);

      // back-to-back handoff and accept on the same edge
      out_ready = 1'b0;
      send(8'h10, 8'h10, 16'h0100);
      wait_valid();
      a = 8'h07; b = 8'h09; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(16'h003F);
      tick();
      in_valid = 1'b0;
      step_chk(4'h7, 4'h9);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b2b_no_valid", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_product", {16'd0, product}, 32'h003F);
      tick();

      // reset in the middle of a multiply
      send(8'h55, 8'h55, 16'h1C39);
      tick(); tick();
      step_chk(4'h5, 4'h5);
      rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_mul", {24'd0, mul_a, mul_b}, 32'd0);
      chk("mid_rst_product", {16'd0, product}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      send(8'h03, 8'h05, 16'h000F);
      wait_valid();
      chk("post_rst_product", {16'd0, product}, 32'h000F);
      tick();

      // zero operand with ZERO_SKIP=1
      z_a = 8'h00; z_b = 8'h9C; z_in_valid = 1'b1;
      #1;
      chk("z_in_ready", {31'd0, z_in_ready}, 32'd1);
      zexp_q.push_back(16'h0000);
      tick();
      z_in_valid = 1'b0;
      chk("z_fast_valid", {31'd0, z_out_valid}, 32'd1);
      chk("z_fast_product", {16'd0, z_product}, 32'd0);
      tick();
      chk("z_drop", {31'd0, z_out_valid}, 32'd0);
      z_a = 8'h9C; z_b = 8'h00; z_in_valid = 1'b1;
      zexp_q.push_back(16'h0000);
      tick();
      z_in_valid = 1'b0;
      chk("z_fast_valid_b", {31'd0, z_out_valid}, 32'd1);
      tick();

      // same zero operand with ZERO_SKIP=0 takes the full four steps
      send(8'h00, 8'h9C, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         chk("noskip_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      chk("noskip_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("noskip_valid", {31'd0, out_valid}, 32'd1);
      chk("noskip_product", {16'd0, product}, 32'd0);
      tick();

      repeat (3) tick();
      chk("sb_drain", exp_q.size(), 32'd0);
      chk("zsb_drain", zexp_q.size(), 32'd0);
      chk("zero_skip_busy", {31'd0, zbusy_seen}, 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
Sequencing controller that computes an unsigned 8x8 product by time-sharing one combinational 4x4 multiplier core over four cycles. It splits the operands into nibbles, drives the core, and shift-accumulates the four partial products into a 16-bit result. The core sits outside this block and is wired to the mul_* ports at the parent level. Operand and result transfers use valid/ready handshakes.

Parameters:
ZERO_SKIP, 0, when 1, an operand pair with a==0 or b==0 bypasses the four multiply steps and produces 0 immediately.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block can accept an operand pair
a  input  8  multiplicand, unsigned
b  input  8  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
product  output  16  a*b, unsigned
mul_a  output  4  nibble operand to 4x4 core
mul_b  output  4  nibble operand to 4x4 core
mul_p  input  8  4x4 core result, combinational from mul_a/mul_b
busy  output  1  high in the MUL state

Behaviour:
- Reset (async assert, sync release): state=IDLE, step=0, acc=0, operand registers=0, product=0, out_valid=0, busy=0, mul_a=mul_b=0. in_ready is forced to 0 while rst is high.
- States:
  - IDLE: in_ready=1.
  - MUL: steps 0..3, 2-bit step counter.
  - DONE: out_valid=1.
- Accept: an accept occurs on a rising edge where in_valid and in_ready are both 1. On accept, a and b are registered, acc=0, step=0, and state goes to MUL.
- ZERO_SKIP=1 and the accepted a or b is 0: state goes directly to DONE with product=0. out_valid is high on the cycle after the accept.
- MUL step schedule (mul_a/mul_b are driven from registered values; mul_p is captured on the same edge):
  - step0: mul_a=a[3:0], mul_b=b[3:0], acc += mul_p
  - step1: mul_a=a[3:0], mul_b=b[7:4], acc += mul_p<<4
  - step2: mul_a=a[7:4], mul_b=b[3:0], acc += mul_p<<4
  - step3: mul_a=a[7:4], mul_b=b[7:4], acc += mul_p<<8
- Width rules: acc is 16 bits. All shifted terms are zero-extended to 16 bits. The final sum is at most 0xFE01, so there is no overflow.
- After step3: product is registered from the final acc value and state goes to DONE. out_valid rises 4 cycles after the accept edge. Latency is 4 clocks accept-to-valid.
- mul_a and mul_b are 0 in IDLE and DONE.
- DONE: product and out_valid hold stable until the edge where out_ready=1.
  - out_ready=1 and in_valid=0: state goes to IDLE and out_valid drops.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). If in_valid is also high in that cycle, the result handoff and the new accept happen on the same edge, and state goes straight to MUL (back-to-back operation).
  - Steady-state throughput is one result per 5 cycles.
- Changes to a/b while the block is not accepting are ignored; inputs are sampled only on accept.
- in_valid is ignored during MUL; in_ready=0 there.
- out_ready is ignored outside DONE.
- rst asserted mid-MUL or mid-DONE: immediate return to reset values and the in-flight result is discarded. No out_valid pulse is produced.
- busy=1 exactly in the MUL state.

Test Plan:
1. Reset, then a=0x12, b=0x34, in_valid for 1 cycle. Required:
   - mul_a/mul_b sequence is 2/4, 2/3, 1/4, 1/3.
   - out_valid rises 4 cycles after the accept edge with product=0x03A8.
2. a=0xFF, b=0xFF -> product=0xFE01. Then a=0x01, b=0x80 -> product=0x0080. out_ready held 1 throughout.
3. a=0xA5, b=0x3C with out_ready=0 for 10 cycles after out_valid. Required: product=0x26AC and out_valid stay constant and in_ready=0. Raise out_ready, then out_valid drops next cycle.
4. Back-to-back: second pair 0x07 x 0x09 presented with in_valid high while in DONE and out_ready=1. Required:
   - first product transferred and second accepted on the same edge.
   - second product=0x003F exactly 4 cycles later.
5. rst pulsed during step2 of 0x55 x 0x55. Required: all outputs return to 0, then in_ready=1 after release. A new 0x03 x 0x05 yields 0x000F with no stale carry-over.
6. ZERO_SKIP=1: a=0x00, b=0x9C -> out_valid on the cycle after accept, product=0, busy never high. With ZERO_SKIP=0, the same input gives out_valid after 4 cycles with product=0.
